// File: rtl/dcache_sa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcache_sa_pkg
// Purpose  : Shared types, widths and helpers for the set-associative dcache
// Revision : 1.0 - initial parametrised release
// ============================================================================
package dcache_sa_pkg;

  // Miss-handling controller states
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WRITEBACK   = 2'd1,
    ALLOCATE    = 2'd2,
    REFILL_DONE = 2'd3
  } state_t;

  // Byte-in-word bits below the word-select field of an address
  localparam int WORD_SEL_LSB = 2;

  function automatic int off_bits(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  function automatic int idx_bits(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_bits(input int addr_w, input int line_w, input int sets);
    return addr_w - idx_bits(sets) - off_bits(line_w);
  endfunction

  // A direct-mapped cache still carries a 1-bit way number so vectors stay legal
  function automatic int way_bits(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_sa_way.sv
`default_nettype none
// ============================================================================
// Module   : dcache_sa_way
// Purpose  : One cache way: valid/dirty/tag/line per set, tag compare,
//            single-word store port and whole-line fill port
// Revision : 1.0 - initial parametrised release
// ============================================================================
module dcache_sa_way
  import dcache_sa_pkg::*;
#(
  parameter int SETS   = 16,
  parameter int IDX_W  = 4,
  parameter int TAG_W  = 23,
  parameter int LINE_W = 256,
  parameter int WORD_W = 32,
  parameter int WSEL_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [TAG_W-1:0]  rd_tag,
  output logic              hit,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_line_tag,
  output logic [LINE_W-1:0] rd_line,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WSEL_W-1:0] wr_word,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              fill_en,
  input  logic [IDX_W-1:0]  fill_idx,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [LINE_W-1:0] fill_line
);

  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [LINE_W-1:0] line_q [SETS];

  assign rd_valid    = valid_q[rd_idx];
  assign rd_dirty    = dirty_q[rd_idx];
  assign rd_line_tag = tag_q[rd_idx];
  assign rd_line     = line_q[rd_idx];
  assign hit         = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

  // Status bits: cleared by reset, set by fill, dirtied by a store hit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_idx] <= 1'b1;
      dirty_q[fill_idx] <= 1'b0;
    end else if (wr_en) begin
      dirty_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data storage need no reset: contents are qualified by valid
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      line_q[fill_idx] <= fill_line;
    end else if (wr_en) begin
      line_q[wr_idx][int'(wr_word)*WORD_W +: WORD_W] <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dcache_sa.sv
`default_nettype none
// ============================================================================
// Module   : dcache_sa
// Purpose  : N-way set-associative write-back, write-allocate data cache
//            with round-robin victim pointer per set and line memory port
// Revision : 1.0 - initial parametrised release
// ============================================================================
module dcache_sa
  import dcache_sa_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int LINE_W = 256,
  parameter int SETS   = 16,
  parameter int WAYS   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [WORD_W-1:0] p1_data_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [WORD_W-1:0] p1_data_o,
  output logic              p1_stall_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  localparam int OFF    = off_bits(LINE_W);
  localparam int IDX    = idx_bits(SETS);
  localparam int TAG    = tag_bits(ADDR_W, LINE_W, SETS);
  localparam int WAY_W  = way_bits(WAYS);
  localparam int WSEL_W = OFF - WORD_SEL_LSB;

  // Request address fields
  logic [TAG-1:0]    req_tag;
  logic [IDX-1:0]    req_idx;
  logic [WSEL_W-1:0] req_word;
  logic              req;
  logic              unused_byte_bits;

  assign req_tag          = p1_addr_i[ADDR_W-1:IDX+OFF];
  assign req_idx          = p1_addr_i[IDX+OFF-1:OFF];
  assign req_word         = p1_addr_i[OFF-1:WORD_SEL_LSB];
  assign req              = p1_MemRead_i | p1_MemWrite_i;
  assign unused_byte_bits = ^p1_addr_i[WORD_SEL_LSB-1:0];

  // Per-way views of the requested set
  logic [WAYS-1:0]   hit_vec;
  logic [WAYS-1:0]   way_valid;
  logic [WAYS-1:0]   way_dirty;
  logic [TAG-1:0]    way_tag  [WAYS];
  logic [LINE_W-1:0] way_line [WAYS];

  // Controller state and latched miss context
  state_t            state_q, state_d;
  logic [WAY_W-1:0]  victim_q, victim_d;
  logic              by_ptr_q, by_ptr_d;
  logic [TAG-1:0]    miss_tag_q, miss_tag_d;
  logic [IDX-1:0]    miss_idx_q, miss_idx_d;
  logic              en_d, we_d;
  logic [ADDR_W-1:0] maddr_d;
  logic [LINE_W-1:0] mdata_d;
  logic [WAY_W-1:0]  vptr_q [SETS];

  logic              any_hit;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  pick;
  logic              pick_by_ptr;
  logic [LINE_W-1:0] hit_line;
  logic [WORD_W-1:0] hit_word;
  logic              word_wr;
  logic              fill;

  assign word_wr = (state_q == IDLE) && p1_MemWrite_i;
  assign fill    = (state_q == ALLOCATE) && mem_ack_i;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    dcache_sa_way #(
      .SETS  (SETS),
      .IDX_W (IDX),
      .TAG_W (TAG),
      .LINE_W(LINE_W),
      .WORD_W(WORD_W),
      .WSEL_W(WSEL_W)
    ) u_way (
      .clk        (clk_i),
      .rst        (rst_i),
      .rd_idx     (req_idx),
      .rd_tag     (req_tag),
      .hit        (hit_vec[w]),
      .rd_valid   (way_valid[w]),
      .rd_dirty   (way_dirty[w]),
      .rd_line_tag(way_tag[w]),
      .rd_line    (way_line[w]),
      .wr_en      (word_wr && hit_vec[w]),
      .wr_idx     (req_idx),
      .wr_word    (req_word),
      .wr_data    (p1_data_i),
      .fill_en    (fill && (victim_q == WAY_W'(w))),
      .fill_idx   (miss_idx_q),
      .fill_tag   (miss_tag_q),
      .fill_line  (mem_data_i)
    );
  end

  // Hit detection and hit-way encoding
  always_comb begin
    any_hit = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (hit_vec[w]) begin
        any_hit = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign hit_line = way_line[hit_way];
  assign hit_word = hit_line[int'(req_word)*WORD_W +: WORD_W];

  // Victim choice: lowest invalid way, otherwise the set's round-robin pointer
  always_comb begin
    pick        = vptr_q[req_idx];
    pick_by_ptr = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!way_valid[w]) begin
        pick        = WAY_W'(w);
        pick_by_ptr = 1'b0;
      end
    end
  end

  // CPU-side outputs; reset forces them quiet even while a request is held
  assign p1_stall_o = !rst_i && ((state_q != IDLE) || (req && !any_hit));
  assign p1_data_o  = (!rst_i && (state_q == IDLE) && p1_MemRead_i && !p1_MemWrite_i && any_hit)
                    ? hit_word : '0;

  // Next-state and next memory-port values
  always_comb begin
    state_d    = state_q;
    victim_d   = victim_q;
    by_ptr_d   = by_ptr_q;
    miss_tag_d = miss_tag_q;
    miss_idx_d = miss_idx_q;
    en_d       = mem_enable_o;
    we_d       = mem_write_o;
    maddr_d    = mem_addr_o;
    mdata_d    = mem_data_o;
    unique case (state_q)
      IDLE: begin
        if (req && !any_hit) begin
          victim_d   = pick;
          by_ptr_d   = pick_by_ptr;
          miss_tag_d = req_tag;
          miss_idx_d = req_idx;
          en_d       = 1'b1;
          if (way_valid[pick] && way_dirty[pick]) begin
            state_d = WRITEBACK;
            we_d    = 1'b1;
            maddr_d = {way_tag[pick], req_idx, {OFF{1'b0}}};
            mdata_d = way_line[pick];
          end else begin
            state_d = ALLOCATE;
            we_d    = 1'b0;
            maddr_d = {req_tag, req_idx, {OFF{1'b0}}};
          end
        end
      end
      WRITEBACK: begin
        if (mem_ack_i) begin
          state_d = ALLOCATE;
          we_d    = 1'b0;
          maddr_d = {miss_tag_q, miss_idx_q, {OFF{1'b0}}};
        end
      end
      ALLOCATE: begin
        if (mem_ack_i) begin
          state_d = REFILL_DONE;
          en_d    = 1'b0;
        end
      end
      REFILL_DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, miss context and registered memory-port outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      victim_q     <= '0;
      by_ptr_q     <= 1'b0;
      miss_tag_q   <= '0;
      miss_idx_q   <= '0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      state_q      <= state_d;
      victim_q     <= victim_d;
      by_ptr_q     <= by_ptr_d;
      miss_tag_q   <= miss_tag_d;
      miss_idx_q   <= miss_idx_d;
      mem_enable_o <= en_d;
      mem_write_o  <= we_d;
      mem_addr_o   <= maddr_d;
      mem_data_o   <= mdata_d;
    end
  end

  // Round-robin pointer advances only when it actually supplied the victim
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) vptr_q[s] <= '0;
    end else if (fill && by_ptr_q) begin
      vptr_q[miss_idx_q] <= (vptr_q[miss_idx_q] == WAY_W'(WAYS - 1))
                          ? '0 : vptr_q[miss_idx_q] + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_sa.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_sa
// Purpose  : Directed self-checking bench for dcache_sa (2-way and 4-way)
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_sa;

  localparam int LAT = 10;

  typedef struct {
    bit           we;
    logic [31:0]  addr;
    logic [255:0] line;
  } mem_txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel4 = 1'b0;
  logic [31:0] p1_addr = '0;
  logic [31:0] p1_wdata = '0;
  logic p1_rd = 1'b0;
  logic p1_wr = 1'b0;
  logic model_ack = 1'b0;
  logic inj_ack = 1'b0;
  logic [255:0] model_rdata = '0;

  logic mem_ack;
  logic [255:0] mem_rdata;
  assign mem_ack   = model_ack | inj_ack;
  assign mem_rdata = inj_ack ? {8{32'hBAD0_BAD0}} : model_rdata;

  logic [31:0]  d2_data, d4_data, d2_maddr, d4_maddr;
  logic [255:0] d2_mdata, d4_mdata;
  logic d2_stall, d4_stall, d2_en, d4_en, d2_we, d4_we;

  // Outputs of whichever instance is currently being exercised
  logic [31:0]  c_data, m_addr;
  logic [255:0] m_wdata;
  logic c_stall, m_en, m_we;
  assign c_data  = sel4 ? d4_data  : d2_data;
  assign c_stall = sel4 ? d4_stall : d2_stall;
  assign m_addr  = sel4 ? d4_maddr : d2_maddr;
  assign m_wdata = sel4 ? d4_mdata : d2_mdata;
  assign m_en    = sel4 ? d4_en    : d2_en;
  assign m_we    = sel4 ? d4_we    : d2_we;

  int n_checks = 0;
  int n_fail   = 0;
  mem_txn_t mem_q[$];
  logic [31:0] rd_q[$];
  logic [255:0] store [logic [31:0]];
  mem_txn_t cur;
  int cnt = 0;

  dcache_sa #(.WAYS(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .p1_addr_i(p1_addr), .p1_data_i(p1_wdata),
    .p1_MemRead_i(p1_rd & ~sel4), .p1_MemWrite_i(p1_wr & ~sel4),
    .p1_data_o(d2_data), .p1_stall_o(d2_stall), .mem_addr_o(d2_maddr),
    .mem_data_o(d2_mdata), .mem_enable_o(d2_en), .mem_write_o(d2_we),
    .mem_data_i(mem_rdata), .mem_ack_i(mem_ack & ~sel4)
  );

  dcache_sa #(.WAYS(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .p1_addr_i(p1_addr), .p1_data_i(p1_wdata),
    .p1_MemRead_i(p1_rd & sel4), .p1_MemWrite_i(p1_wr & sel4),
    .p1_data_o(d4_data), .p1_stall_o(d4_stall), .mem_addr_o(d4_maddr),
    .mem_data_o(d4_mdata), .mem_enable_o(d4_en), .mem_write_o(d4_we),
    .mem_data_i(mem_rdata), .mem_ack_i(mem_ack & sel4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] pattern(input logic [31:0] a);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = {a[15:0], 8'hC0, 8'(k)};
    return l;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    if (store.exists(a)) return store[a];
    return pattern(a);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [255:0] l;
    l = mem_line({a[31:5], 5'b0});
    return l[32*int'(a[4:2]) +: 32];
  endfunction

  task automatic expect_mem(input bit we, input logic [31:0] a, input logic [255:0] line);
    mem_txn_t t;
    t.we = we; t.addr = a; t.line = line;
    mem_q.push_back(t);
  endtask

  // Line memory: acks after LAT enabled cycles, checks each transfer against the scoreboard
  always @(negedge clk) begin
    model_ack = 1'b0;
    if (rst || !m_en) begin
      cnt = 0;
    end else if (cnt == LAT - 1) begin
      cnt = 0;
      model_ack = 1'b1;
      check("mem_txn_expected", mem_q.size() != 0, 1'b1);
      if (mem_q.size() != 0) begin
        cur = mem_q.pop_front();
        check("mem_write", m_we, cur.we);
        check("mem_addr", m_addr, cur.addr);
        if (cur.we) check("mem_wb_line", m_wdata, cur.line);
      end
      if (m_we) store[m_addr] = m_wdata;
      else      model_rdata = mem_line(m_addr);
    end else begin
      cnt++;
    end
  end

  // One CPU access; exp_cycles is the number of cycles stall is expected high
  task automatic access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input int exp_cycles);
    int cyc;
    logic [31:0] e;
    @(negedge clk);
    p1_addr = a; p1_wdata = wd; p1_wr = we; p1_rd = !we;
    if (!we) rd_q.push_back(exp_rd);
    #1;
    check("stall_on_request", c_stall, exp_cycles != 0);
    if (exp_cycles == 0) check("no_mem_on_hit", m_en, 1'b0);
    cyc = 0;
    while (c_stall && cyc < 200) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    check("stall_cycles", cyc, exp_cycles);
    if (!we && rd_q.size() != 0) begin
      e = rd_q.pop_front();
      check("load_data", c_data, e);
    end
    @(negedge clk);
    p1_rd = 1'b0; p1_wr = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_stall", c_stall, 1'b0);
    check("rst_mem_en", m_en, 1'b0);
    check("rst_mem_we", m_we, 1'b0);
    check("rst_mem_addr", m_addr, 32'h0);
    check("rst_mem_data", m_wdata, 256'h0);
    check("rst_p1_data", c_data, 32'h0);
  endtask

  initial begin
    logic [255:0] l;
    l = pattern(32'h40);
    l[31:0] = 32'h1111_1111;
    store[32'h40] = l;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;

    // Cold read miss, then data returned two cycles after ack
    expect_mem(1'b0, 32'h40, '0);
    access(1'b0, 32'h40, '0, 32'h1111_1111, 1 + LAT + 1);

    // Store hit then load hits
    access(1'b1, 32'h44, 32'hDEAD_BEEF, '0, 0);
    access(1'b0, 32'h44, '0, 32'hDEAD_BEEF, 0);
    access(1'b0, 32'h40, '0, 32'h1111_1111, 0);

    // Fill way1, then evict dirty way0 with writeback before allocate
    expect_mem(1'b0, 32'h240, '0);
    access(1'b0, 32'h240, '0, mem_word(32'h240), 1 + LAT + 1);
    l = mem_line(32'h40);
    l[63:32] = 32'hDEAD_BEEF;
    expect_mem(1'b1, 32'h40, l);
    expect_mem(1'b0, 32'h440, '0);
    access(1'b0, 32'h44C, '0, mem_word(32'h44C), 1 + LAT + LAT + 1);
    access(1'b0, 32'h248, '0, mem_word(32'h248), 0);

    // Asynchronous reset in the middle of an allocate
    expect_mem(1'b0, 32'h640, '0);
    @(negedge clk);
    p1_addr = 32'h640; p1_rd = 1'b1;
    #1;
    check("miss_stall_0x640", c_stall, 1'b1);
    repeat (4) @(negedge clk);
    #1;
    check("alloc_en", m_en, 1'b1);
    check("alloc_addr", m_addr, 32'h640);
    #1;
    rst = 1'b1; p1_rd = 1'b0;
    #1;
    check("async_rst_en", m_en, 1'b0);
    check("async_rst_stall", c_stall, 1'b0);
    check_reset_outputs();
    mem_q.delete();
    @(negedge clk);
    rst = 1'b0;
    expect_mem(1'b0, 32'h40, '0);
    access(1'b0, 32'h40, '0, 32'h1111_1111, 1 + LAT + 1);
    access(1'b0, 32'h44, '0, 32'hDEAD_BEEF, 0);

    // Stray ack in IDLE must not touch anything
    @(negedge clk);
    inj_ack = 1'b1;
    #1;
    check("stray_ack_stall", c_stall, 1'b0);
    @(negedge clk);
    inj_ack = 1'b0;
    #1;
    check("stray_ack_en", m_en, 1'b0);
    access(1'b0, 32'h40, '0, 32'h1111_1111, 0);
    expect_mem(1'b0, 32'h640, '0);
    access(1'b0, 32'h640, '0, mem_word(32'h640), 1 + LAT + 1);

    // Four-way instance: fifth clean miss in one set evicts way0 via the pointer
    @(negedge clk);
    sel4 = 1'b1; rst = 1'b1;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      logic [31:0] a;
      a = 32'h40 + 32'(i) * 32'h200;
      expect_mem(1'b0, a, '0);
      access(1'b0, a, '0, mem_word(a), 1 + LAT + 1);
    end
    access(1'b0, 32'h248, '0, mem_word(32'h248), 0);
    expect_mem(1'b0, 32'h40, '0);
    access(1'b0, 32'h40, '0, mem_word(32'h40), 1 + LAT + 1);
    access(1'b0, 32'h444, '0, mem_word(32'h444), 0);
    access(1'b0, 32'h85C, '0, mem_word(32'h85C), 0);

    repeat (2) @(negedge clk);
    check("mem_scoreboard_drained", mem_q.size(), 0);
    check("load_scoreboard_drained", rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute bound on run time
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
